// File: rtl/sram_mem_controller_pkg.sv
// sram_mem_controller_pkg: shared widths, default SRAM base address and controller state encoding.
package sram_mem_controller_pkg;
    localparam int WORD_WIDTH = 32;
    localparam int SRAM_DATA_W = 16;
    localparam logic [WORD_WIDTH-1:0] DEFAULT_BASE_ADDR = 32'd1024;
    typedef enum logic [1:0] {SRAM_IDLE, SRAM_LOW, SRAM_HIGH, SRAM_DONE} sram_state_t;
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter timing one SRAM half-word access phase.
module sram_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last,
    output logic         next_last
);
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else if (load) count <= load_val;
        else if (count != '0) count <= count - 1'b1;
    end
    assign last = count == '0;
    assign next_last = count == W'(1);
endmodule

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: 32-bit MEM-stage port onto a 16-bit async SRAM as two timed half-word accesses.
// Define SRAM_ADDR_CHECK_EN to reject out-of-range addresses and expose addr_err.
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter logic [WORD_WIDTH-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [WORD_WIDTH-1:0]  address,
    input  logic [WORD_WIDTH-1:0]  write_data,
    output logic [WORD_WIDTH-1:0]  read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
`ifdef SRAM_ADDR_CHECK_EN
    output logic                   addr_err,
`endif
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ce_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);
    localparam logic [3:0] LOAD_VAL = 4'(ACCESS_CYCLES - 1);
    sram_state_t state;
    logic is_wr, req, last, next_last, load, addr_bad;
    logic [SRAM_ADDR_W-2:0] word_idx, req_idx;
    logic [SRAM_DATA_W-1:0] wdata_hi, rdata_lo;
    logic [WORD_WIDTH-1:0] offset;
    assign req = rd_en | wr_en;
    assign offset = address - BASE_ADDR;
    assign req_idx = (SRAM_ADDR_W-1)'(offset >> 2);
`ifdef SRAM_ADDR_CHECK_EN
    assign addr_bad = (address < BASE_ADDR) || ((offset >> (SRAM_ADDR_W + 1)) != '0);
`else
    assign addr_bad = 1'b0;
`endif
    assign ready = (state == SRAM_IDLE) ? ~req : (state == SRAM_DONE);
    assign load = (state == SRAM_IDLE && req) || (state == SRAM_LOW && last);
    sram_wait_counter #(.W(4)) u_wait (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_val  (LOAD_VAL),
        .last      (last),
        .next_last (next_last)
    );
    // we_n rises one cycle before each phase ends so every half gets its own write edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SRAM_IDLE;
            is_wr <= 1'b0;
            word_idx <= '0;
            wdata_hi <= '0;
            rdata_lo <= '0;
            read_data <= '0;
            sram_addr <= '0;
            sram_dq_out <= '0;
            sram_dq_oe <= 1'b0;
            {sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n} <= '1;
`ifdef SRAM_ADDR_CHECK_EN
            addr_err <= 1'b0;
`endif
        end else begin
            case (state)
                SRAM_IDLE: if (req) begin
                    is_wr <= wr_en;
                    word_idx <= req_idx;
                    wdata_hi <= write_data[WORD_WIDTH-1:SRAM_DATA_W];
                    if (addr_bad) begin
                        state <= SRAM_DONE;
                        if (!wr_en) read_data <= '0;
`ifdef SRAM_ADDR_CHECK_EN
                        addr_err <= 1'b1;
`endif
                    end else begin
                        state <= SRAM_LOW;
                        sram_addr <= {req_idx, 1'b0};
                        sram_dq_out <= write_data[SRAM_DATA_W-1:0];
                        sram_dq_oe <= wr_en;
                        {sram_ce_n, sram_ub_n, sram_lb_n} <= '0;
                        sram_we_n <= ~wr_en;
                        sram_oe_n <= wr_en;
                    end
                end
                SRAM_LOW: if (last) begin
                    state <= SRAM_HIGH;
                    sram_addr <= {word_idx, 1'b1};
                    sram_dq_out <= wdata_hi;
                    sram_we_n <= ~is_wr;
                    if (!is_wr) rdata_lo <= sram_dq_in;
                end else if (next_last) sram_we_n <= 1'b1;
                SRAM_HIGH: if (last) begin
                    state <= SRAM_DONE;
                    {sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n} <= '1;
                    sram_dq_oe <= 1'b0;
                    if (!is_wr) read_data <= {sram_dq_in, rdata_lo};
                end else if (next_last) sram_we_n <= 1'b1;
                SRAM_DONE: begin
                    state <= SRAM_IDLE;
`ifdef SRAM_ADDR_CHECK_EN
                    addr_err <= 1'b0;
`endif
                end
                default: state <= SRAM_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: directed and randomized checks of sram_mem_controller against a word-level memory model.
module tb_sram_mem_controller;
    localparam int AC = 2;
    localparam int AW = 18;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int LAT = 2 * AC + 1;
    localparam int WORDS = 1 << (AW - 1);

    logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic ready, sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
    logic [AW-1:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
`ifdef SRAM_ADDR_CHECK_EN
    logic addr_err;
`endif

    int n_pass = 0, n_total = 0;
    logic [31:0] exp_rd = '0;
    logic [31:0] ref_mem [int];

    logic [15:0] sram [0:(1<<AW)-1];
    logic pend = 1'b0;
    logic [AW-1:0] pa;
    logic [15:0] pd;

    sram_mem_controller #(.ACCESS_CYCLES(AC), .BASE_ADDR(BASE), .SRAM_ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
`ifdef SRAM_ADDR_CHECK_EN
        .addr_err    (addr_err),
`endif
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n),
        .sram_ce_n   (sram_ce_n),
        .sram_ub_n   (sram_ub_n),
        .sram_lb_n   (sram_lb_n)
    );

    always #5 clk = ~clk;

    // Async SRAM: a write commits when we_n rises while the chip is still selected
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr] : 16'h0000;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            pend <= 1'b1;
            pa <= sram_addr;
            pd <= sram_dq_out;
        end else begin
            if (pend && !sram_ce_n) sram[pa] <= pd;
            pend <= 1'b0;
        end
    end

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) % WORDS);
    endfunction

    task automatic run_txn(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output int we_lo, output int oe_lo, output int ce_lo);
        wr_en = w;
        rd_en = r;
        address = a;
        write_data = d;
        lat = -1;
        we_lo = 0;
        oe_lo = 0;
        ce_lo = 0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (ready) begin
                lat = c;
                break;
            end
            if (!sram_we_n) we_lo++;
            if (!sram_oe_n) oe_lo++;
            if (!sram_ce_n) ce_lo++;
            if (c == 1) write_data = ~d;
            @(negedge clk);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        n_total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else n_pass++;
        n_total++; if ({sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n} !== 5'b11111)
            $display("FAIL reset_strobes: got %b expected 11111", {sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}); else n_pass++;
        n_total++; if (sram_dq_oe !== 1'b0) $display("FAIL reset_oe: got %b expected 0", sram_dq_oe); else n_pass++;
        n_total++; if (sram_addr !== '0) $display("FAIL reset_addr: got %h expected 0", sram_addr); else n_pass++;
        n_total++; if (sram_dq_out !== '0) $display("FAIL reset_dq: got %h expected 0", sram_dq_out); else n_pass++;
        n_total++; if (read_data !== '0) $display("FAIL reset_rdata: got %h expected 0", read_data); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_idle;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if ({ready, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 7'b1111110)
                $display("FAIL idle_%0d: got %b expected 1111110", i,
                         {ready, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n, sram_dq_oe});
            else n_pass++;
        end
    endtask

    task automatic test_write;
        int lat, we_lo, oe_lo, ce_lo;
        run_txn(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lat, we_lo, oe_lo, ce_lo);
        ref_mem[0] = 32'hDEADBEEF;
        n_total++; if (lat !== LAT) $display("FAIL write_latency: got %0d expected %0d", lat, LAT); else n_pass++;
        n_total++; if (we_lo !== 2 * (AC - 1)) $display("FAIL write_we_cycles: got %0d expected %0d", we_lo, 2 * (AC - 1)); else n_pass++;
        n_total++; if (ce_lo !== 2 * AC || oe_lo !== 0) $display("FAIL write_ce_oe: got ce %0d oe %0d expected ce %0d oe 0", ce_lo, oe_lo, 2 * AC); else n_pass++;
        n_total++; if (sram_we_n !== 1'b1 || sram_ce_n !== 1'b1) $display("FAIL write_done_strobes: got we %b ce %b expected 1 1", sram_we_n, sram_ce_n); else n_pass++;
        @(negedge clk);
        n_total++; if (sram[0] !== 16'hBEEF) $display("FAIL write_sram0: got %h expected beef", sram[0]); else n_pass++;
        n_total++; if (sram[1] !== 16'hDEAD) $display("FAIL write_sram1: got %h expected dead", sram[1]); else n_pass++;
    endtask

    task automatic test_read;
        int lat, we_lo, oe_lo, ce_lo;
        logic [31:0] d;
        run_txn(1'b0, 1'b1, 32'd1026, 32'h0, lat, we_lo, oe_lo, ce_lo);
        exp_rd = ref_mem[0];
        n_total++; if (lat !== LAT) $display("FAIL read_latency: got %0d expected %0d", lat, LAT); else n_pass++;
        n_total++; if (read_data !== exp_rd) $display("FAIL read_data: got %h expected %h", read_data, exp_rd); else n_pass++;
        n_total++; if (oe_lo !== 2 * AC || we_lo !== 0) $display("FAIL read_strobes: got oe %0d we %0d expected oe %0d we 0", oe_lo, we_lo, 2 * AC); else n_pass++;
        @(negedge clk);
        d = $urandom;
        run_txn(1'b1, 1'b0, 32'd1028, d, lat, we_lo, oe_lo, ce_lo);
        ref_mem[1] = d;
        n_total++; if (read_data !== exp_rd) $display("FAIL read_hold: got %h expected %h", read_data, exp_rd); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_both;
        int lat, we_lo, oe_lo, ce_lo;
        run_txn(1'b1, 1'b1, 32'd1032, 32'h12345678, lat, we_lo, oe_lo, ce_lo);
        ref_mem[2] = 32'h12345678;
        n_total++; if (lat !== LAT) $display("FAIL both_latency: got %0d expected %0d", lat, LAT); else n_pass++;
        n_total++; if (read_data !== exp_rd) $display("FAIL both_rdata: got %h expected %h", read_data, exp_rd); else n_pass++;
        @(negedge clk);
        n_total++; if ({sram[5], sram[4]} !== 32'h12345678) $display("FAIL both_sram: got %h expected 12345678", {sram[5], sram[4]}); else n_pass++;
    endtask

    task automatic test_reset_abort;
        int lat, we_lo, oe_lo, ce_lo;
        sram[6] = 16'h0000;
        sram[7] = 16'hA5A5;
        wr_en = 1'b1;
        address = 32'd1036;
        write_data = 32'hCAFE1357;
        repeat (AC + 1) @(negedge clk);
        #1;
        n_total++; if (sram_we_n !== 1'b0 || sram_addr !== AW'(7)) $display("FAIL abort_in_high: got we %b addr %0d expected 0 7", sram_we_n, sram_addr); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if ({sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 6'b111110)
            $display("FAIL abort_strobes: got %b expected 111110", {sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n, sram_dq_oe}); else n_pass++;
        n_total++; if (sram_addr !== '0 || read_data !== '0) $display("FAIL abort_regs: got addr %h rdata %h expected 0 0", sram_addr, read_data); else n_pass++;
        exp_rd = '0;
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ref_mem[3] = {16'hA5A5, 16'h1357};
        n_total++; if ({sram[7], sram[6]} !== ref_mem[3]) $display("FAIL abort_sram: got %h expected %h", {sram[7], sram[6]}, ref_mem[3]); else n_pass++;
        run_txn(1'b0, 1'b1, 32'd1036, 32'h0, lat, we_lo, oe_lo, ce_lo);
        exp_rd = ref_mem[3];
        n_total++; if (lat !== LAT || read_data !== exp_rd) $display("FAIL abort_restart: got lat %0d data %h expected %0d %h", lat, read_data, LAT, exp_rd); else n_pass++;
        @(negedge clk);
    endtask

`ifdef SRAM_ADDR_CHECK_EN
    task automatic test_addr_check;
        int lat, we_lo, oe_lo, ce_lo;
        run_txn(1'b0, 1'b1, 32'd1000, 32'h0, lat, we_lo, oe_lo, ce_lo);
        exp_rd = '0;
        n_total++; if (lat !== 1) $display("FAIL chk_latency: got %0d expected 1", lat); else n_pass++;
        n_total++; if (addr_err !== 1'b1) $display("FAIL chk_err: got %b expected 1", addr_err); else n_pass++;
        n_total++; if (read_data !== exp_rd) $display("FAIL chk_rdata: got %h expected %h", read_data, exp_rd); else n_pass++;
        n_total++; if (ce_lo !== 0 || sram_ce_n !== 1'b1) $display("FAIL chk_ce: got %0d low cycles expected 0", ce_lo); else n_pass++;
        @(negedge clk);
        n_total++; if (addr_err !== 1'b0) $display("FAIL chk_err_clear: got %b expected 0", addr_err); else n_pass++;
    endtask
`endif

    task automatic test_random;
        int lat, we_lo, oe_lo, ce_lo, k, sel, op, w;
        logic [31:0] a, d, e;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 7);
            sel = $urandom_range(0, 2);
`ifdef SRAM_ADDR_CHECK_EN
            sel = 0;
`endif
            op = $urandom_range(0, 2);
            d = $urandom;
            a = BASE + 32'(4 * (100 + k)) + 32'($urandom_range(0, 3));
            if (sel == 1) a = a + 32'(4 * WORDS);
            if (sel == 2) a = a - 32'(4 * WORDS);
            w = word_of(a);
            run_txn(op != 1, op != 0, a, d, lat, we_lo, oe_lo, ce_lo);
            n_total++; if (lat !== LAT) $display("FAIL rand_latency_%0d: got %0d expected %0d", i, lat, LAT); else n_pass++;
            if (op != 1) ref_mem[w] = d;
            else exp_rd = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
            n_total++; if (read_data !== exp_rd) $display("FAIL rand_rdata_%0d: got %h expected %h", i, read_data, exp_rd); else n_pass++;
            @(negedge clk);
            if (op != 1) begin
                e = ref_mem[w];
                n_total++; if ({sram[2*w+1], sram[2*w]} !== e) $display("FAIL rand_sram_%0d: got %h expected %h", i, {sram[2*w+1], sram[2*w]}, e); else n_pass++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = 16'h0000;
        test_reset;
        test_idle;
        test_write;
        test_read;
        test_both;
        test_reset_abort;
`ifdef SRAM_ADDR_CHECK_EN
        test_addr_check;
`endif
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
